// File: rtl/ppu_pkg.sv
// Shared PPU-side definitions: sprite-DMA state encoding and the OAMDMA register constants.
package ppu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } dma_state_t;

  localparam logic [15:0] OAMDMA_ADDR = 16'h4014;
  localparam int unsigned OAM_BYTES   = 256;

  // True for a CPU write that hits the OAMDMA trigger register.
  function automatic logic is_oamdma_write(input logic [15:0] addr, input logic wr);
    return wr && (addr == OAMDMA_ADDR);
  endfunction

endpackage

// File: rtl/oam_dma_engine.sv
// Sprite-DMA master: halts the CPU, reads one 256-byte CPU page and streams it into OAMDATA.
module oam_dma_engine
  import ppu_pkg::*;
#(
  parameter int unsigned XFER_LEN = OAM_BYTES,
  parameter int unsigned IDX_W    = 8
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        cpu_ce,
  input  logic        dma_start,
  input  logic [7:0]  dma_page,
  input  logic [7:0]  mem_rdata,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        cpu_halt,
  output logic [7:0]  dma_data,
  output logic        dma_select,
  output logic        busy,
  output logic        done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(XFER_LEN - 1);

  dma_state_t       state, state_d;
  logic [IDX_W-1:0] idx, idx_d;
  logic [7:0]       page_q, page_d;
  logic [7:0]       data_q, data_d;
  logic             parity;

  // State and datapath registers; everything advances only on a CPU cycle boundary.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= IDLE;
      idx    <= '0;
      page_q <= '0;
      data_q <= '0;
    end else if (cpu_ce) begin
      state  <= state_d;
      idx    <= idx_d;
      page_q <= page_d;
      data_q <= data_d;
    end
  end

  // CPU cycle parity: 0 marks an even cycle, used to pick the extra alignment cycle.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      parity <= 1'b0;
    end else if (cpu_ce) begin
      parity <= ~parity;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d    = state;
    idx_d      = idx;
    page_d     = page_q;
    data_d     = data_q;
    mem_addr   = '0;
    mem_rd     = 1'b0;
    dma_select = 1'b0;
    done       = 1'b0;
    busy       = 1'b1;

    case (state)
      IDLE: begin
        busy = 1'b0;
        if (dma_start) begin
          page_d  = dma_page;
          idx_d   = '0;
          state_d = HALT;
        end
      end
      HALT: begin
        state_d = parity ? ALIGN : READ;
      end
      ALIGN: begin
        state_d = READ;
      end
      READ: begin
        mem_addr = {page_q, idx};
        mem_rd   = 1'b1;
        data_d   = mem_rdata;
        state_d  = WRITE;
      end
      WRITE: begin
        // Qualified by cpu_ce so the register block sees exactly one Clk-wide strobe.
        dma_select = cpu_ce;
        if (idx == LAST_IDX) begin
          done    = cpu_ce;
          idx_d   = '0;
          state_d = IDLE;
        end else begin
          idx_d   = idx + IDX_W'(1);
          state_d = READ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    cpu_halt = busy;
  end

  assign dma_data = data_q;

endmodule

// File: tb/tb_oam_dma_engine.sv
// Directed bench for oam_dma_engine: table of full transfers plus hand-written corner sequences.
module tb_oam_dma_engine;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        cpu_ce = 1'b0;
  logic        dma_start = 1'b0;
  logic [7:0]  dma_page = 8'h00;
  logic [7:0]  mem_rdata;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        cpu_halt;
  logic [7:0]  dma_data;
  logic        dma_select;
  logic        busy;
  logic        done;

  oam_dma_engine dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .cpu_ce     (cpu_ce),
    .dma_start  (dma_start),
    .dma_page   (dma_page),
    .mem_rdata  (mem_rdata),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .cpu_halt   (cpu_halt),
    .dma_data   (dma_data),
    .dma_select (dma_select),
    .busy       (busy),
    .done       (done)
  );

  always #5 Clk = ~Clk;

  // Memory model: each byte is its low address byte XOR 5A.
  assign mem_rdata = mem_addr[7:0] ^ 8'h5A;

  // cpu_ce every third Clk, changed just after the rising edge; ce_total mirrors the parity count.
  bit ce_en = 1'b1;
  int ce_div = 0;
  int ce_total = 0;
  always @(posedge Clk) begin
    if (!Reset_n) ce_total = 0;
    else if (cpu_ce) ce_total++;
    #1;
    if (ce_en) begin
      ce_div = (ce_div == 2) ? 0 : ce_div + 1;
      cpu_ce = (ce_div == 2);
    end else begin
      cpu_ce = 1'b0;
    end
  end

  // Passive monitor on the falling edge.
  logic [15:0] addr_log[$];
  logic [7:0]  data_log[$];
  int halt_ce = 0, pre_cnt = 0, done_cnt = 0, bad_sel = 0;
  bit in_pre = 1'b1;
  always @(negedge Clk) begin
    if (Reset_n) begin
      if (!cpu_halt) in_pre = 1'b1;
      if (dma_select && !cpu_ce) bad_sel++;
      if (cpu_ce) begin
        if (cpu_halt) begin
          halt_ce++;
          if (mem_rd) in_pre = 1'b0;
          else if (in_pre) pre_cnt++;
        end
        if (mem_rd) addr_log.push_back(mem_addr);
        if (dma_select) data_log.push_back(dma_data);
        if (done) done_cnt++;
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int a_base, d_base, h_base, p_base, dn_base;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge Clk);
    #1;
  endtask

  task automatic chk_outputs_zero(input string name);
    chk({name, ".mem_addr"}, 32'(mem_addr), 32'h0);
    chk({name, ".mem_rd"}, 32'(mem_rd), 32'h0);
    chk({name, ".cpu_halt"}, 32'(cpu_halt), 32'h0);
    chk({name, ".dma_data"}, 32'(dma_data), 32'h0);
    chk({name, ".dma_select"}, 32'(dma_select), 32'h0);
    chk({name, ".busy"}, 32'(busy), 32'h0);
    chk({name, ".done"}, 32'(done), 32'h0);
  endtask

  // Issue a start on a cpu_ce whose following HALT cycle has the requested parity.
  task automatic launch(input logic [7:0] page, input bit odd);
    int t = 0;
    step();
    while (!(cpu_ce && !busy && ((ce_total % 2) == (odd ? 0 : 1))) && t < 100) begin
      step();
      t++;
    end
    chk("launch_timeout", 32'(t >= 100), 32'h0);
    a_base = addr_log.size(); d_base = data_log.size();
    h_base = halt_ce; p_base = pre_cnt; dn_base = done_cnt;
    dma_page  = page;
    dma_start = 1'b1;
    step();
    dma_start = 1'b0;
    dma_page  = 8'h00;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (!busy && t < 20) begin step(); t++; end
    while (busy && t < 4000) begin step(); t++; end
    chk({name, ".timeout"}, 32'(t >= 4000), 32'h0);
  endtask

  task automatic wait_bytes(input int n);
    int t = 0;
    while ((data_log.size() - d_base) < n && t < 4000) begin step(); t++; end
    chk("wait_bytes_timeout", 32'(t >= 4000), 32'h0);
  endtask

  task automatic finish_check(input string name, input logic [7:0] page, input int exp_halt,
                              input int exp_pre, input logic [15:0] exp_last);
    int abad = 0, dbad = 0;
    int na = addr_log.size() - a_base;
    int nd = data_log.size() - d_base;
    logic [7:0] ib;
    chk({name, ".pulses"}, 32'(nd), 32'd256);
    chk({name, ".reads"}, 32'(na), 32'd256);
    for (int i = 0; i < 256; i++) begin
      ib = 8'(i);
      if (i < na && addr_log[a_base + i] !== {page, ib}) abad++;
      if (i < nd && data_log[d_base + i] !== (ib ^ 8'h5A)) dbad++;
    end
    chk({name, ".addr_errs"}, 32'(abad), 32'h0);
    chk({name, ".data_errs"}, 32'(dbad), 32'h0);
    if (na > 0) chk({name, ".last_addr"}, 32'(addr_log[addr_log.size() - 1]), 32'(exp_last));
    chk({name, ".halt_ce"}, 32'(halt_ce - h_base), 32'(exp_halt));
    chk({name, ".pre_read"}, 32'(pre_cnt - p_base), 32'(exp_pre));
    chk({name, ".done_cnt"}, 32'(done_cnt - dn_base), 32'h1);
    chk({name, ".bad_sel"}, 32'(bad_sel), 32'h0);
    chk({name, ".idle_rd"}, 32'(mem_rd), 32'h0);
    chk({name, ".idle_addr"}, 32'(mem_addr), 32'h0);
    chk({name, ".idle_halt"}, 32'(cpu_halt), 32'h0);
    chk({name, ".held_data"}, 32'(dma_data), 32'hA5);
  endtask

  typedef struct {
    string       name;
    logic [7:0]  page;
    bit          odd;
    int          exp_halt;
    int          exp_pre;
    logic [15:0] exp_last;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{"even_p02", 8'h02, 1'b0, 513, 1, 16'h02FF};
    vecs[1] = '{"odd_p02",  8'h02, 1'b1, 514, 2, 16'h02FF};
    vecs[2] = '{"even_pFF", 8'hFF, 1'b0, 513, 1, 16'hFFFF};
    vecs[3] = '{"odd_p80",  8'h80, 1'b1, 514, 2, 16'h80FF};

    repeat (3) step();
    chk_outputs_zero("reset");
    Reset_n = 1'b1;
    repeat (4) step();
    chk_outputs_zero("idle");

    for (int v = 0; v < 4; v++) begin
      launch(vecs[v].page, vecs[v].odd);
      wait_idle(vecs[v].name);
      finish_check(vecs[v].name, vecs[v].page, vecs[v].exp_halt, vecs[v].exp_pre, vecs[v].exp_last);
    end

    // Restart attempt mid-transfer, then again in the completing cycle.
    begin
      int t = 0;
      launch(8'h02, 1'b0);
      wait_bytes(40);
      while (!cpu_ce) step();
      dma_page = 8'h07; dma_start = 1'b1;
      step();
      dma_start = 1'b0;
      while (!(cpu_ce && done) && t < 4000) begin step(); t++; end
      chk("restart.done_timeout", 32'(t >= 4000), 32'h0);
      dma_start = 1'b1;
      step();
      dma_start = 1'b0; dma_page = 8'h00;
      repeat (12) step();
      chk("restart.no_late_start", 32'(busy), 32'h0);
      finish_check("restart", 8'h02, 513, 1, 16'h02FF);
    end

    // Reset mid-transfer, then a clean transfer from page 03.
    launch(8'h02, 1'b0);
    wait_bytes(100);
    Reset_n = 1'b0;
    #1;
    chk_outputs_zero("midrst");
    repeat (2) step();
    chk("midrst.busy_held", 32'(busy), 32'h0);
    Reset_n = 1'b1;
    launch(8'h03, 1'b0);
    wait_idle("rst_restart");
    finish_check("rst_restart", 8'h03, 513, 1, 16'h03FF);

    // cpu_ce held low for 50 Clk while parked in WRITE.
    begin
      int t = 0, viol = 0;
      launch(8'h02, 1'b1);
      while (!(cpu_ce && mem_rd && (data_log.size() - d_base) == 20) && t < 4000) begin step(); t++; end
      chk("cehold.timeout", 32'(t >= 4000), 32'h0);
      ce_en = 1'b0;
      repeat (50) begin
        step();
        if (dma_select || mem_rd || !busy || cpu_ce) viol++;
      end
      chk("cehold.frozen", 32'(viol), 32'h0);
      chk("cehold.data", 32'(dma_data), 32'h4E);
      chk("cehold.pulses", 32'(data_log.size() - d_base), 32'd20);
      ce_en = 1'b1;
      t = 0;
      while (!cpu_ce && t < 10) begin step(); t++; end
      chk("cehold.sel_on_ce", 32'(dma_select), 32'h1);
      chk("cehold.one_pulse", 32'(data_log.size() - d_base), 32'd21);
      wait_idle("cehold");
      finish_check("cehold", 8'h02, 514, 2, 16'h02FF);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
